// File: rtl/zombie_pkg.sv
// Shared types and constants for the punch-zombie target generator.
// Holds the FSM state encoding, the round result and the LFSR tap masks.
package zombie_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SPAWN,
      WAIT,
      FLASH,
      OVER
   } state_t;

   typedef enum logic {
      RES_HIT,
      RES_MISS
   } result_t;

   // Right-shift Galois masks: bit k set means x^(k+1) appears in the polynomial.
   function automatic logic [31:0] lfsr_taps(input int width);
      case (width)
         8:       lfsr_taps = 32'h0000_00B8;  // x^8+x^6+x^5+x^4+1
         16:      lfsr_taps = 32'h0000_B400;  // x^16+x^14+x^13+x^11+1
         default: lfsr_taps = 32'h8020_0003;  // x^32+x^22+x^2+x+1
      endcase
   endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser plus rising-edge detector for a vector of raw buttons.
// The registered edge vector shows a raw rise on the third clock edge.
module btn_sync_edge #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] rise
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;
   logic [WIDTH-1:0] dly_q;
   logic [WIDTH-1:0] rise_q;

   // NOTE: non-blocking assignments let every flop sample the pre-edge value,
   // which is what makes this a real shift chain rather than one wire.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= '0;
         sync_q <= '0;
         dly_q  <= '0;
         rise_q <= '0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
         dly_q  <= sync_q;
         rise_q <= sync_q & ~dly_q;
      end
   end

   assign rise = rise_q;

endmodule

// File: rtl/zombie_target_gen.sv
// Target generator and hit judge: lights a pseudo-random hole, judges presses,
// keeps score/miss counts and ends the game after MAX_MISS misses.
module zombie_target_gen
   import zombie_pkg::*;
#(
   parameter int          N_HOLES     = 3,
   parameter int          LFSR_W      = 16,
   parameter logic [31:0] SEED        = 32'h0000_ACE1,
   parameter int          TIMEOUT_CYC = 31250000,
   parameter int          FLASH_CYC   = 6250000,
   parameter int          SCORE_W     = 8,
   parameter int          MAX_MISS    = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [N_HOLES-1:0] btn,
   output logic [N_HOLES-1:0] led,
   output logic               hit,
   output logic               miss,
   output logic [SCORE_W-1:0] score,
   output logic [SCORE_W-1:0] misses,
   output logic               game_over
);

   localparam int IDX_W   = (N_HOLES > 1) ? $clog2(N_HOLES) : 1;
   localparam int T_MAX   = (TIMEOUT_CYC > FLASH_CYC) ? TIMEOUT_CYC : FLASH_CYC;
   localparam int TIMER_W = $clog2(T_MAX + 1);

   localparam logic [LFSR_W-1:0]  TAPS     = LFSR_W'(lfsr_taps(LFSR_W));
   localparam logic [LFSR_W-1:0]  SEED_EFF = (SEED[LFSR_W-1:0] == '0) ? LFSR_W'(1)
                                                                      : SEED[LFSR_W-1:0];
   localparam logic [TIMER_W-1:0] T_WAIT   = TIMER_W'(TIMEOUT_CYC - 1);
   localparam logic [TIMER_W-1:0] T_FLASH  = TIMER_W'(FLASH_CYC - 1);
   localparam logic [SCORE_W-1:0] MISS_LIM = SCORE_W'(MAX_MISS);

   state_t               state_q, state_d;
   result_t              result_q, result_d;
   logic [LFSR_W-1:0]    lfsr_q;
   logic [IDX_W-1:0]     target_q, target_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic [SCORE_W-1:0]   score_q, score_d;
   logic [SCORE_W-1:0]   misses_q, misses_d;
   logic                 blink_q, blink_d;
   logic                 hit_q, hit_d;
   logic                 miss_q, miss_d;
   logic [N_HOLES-1:0]   btn_rise;
   logic [N_HOLES-1:0]   target_oh;
   logic [IDX_W-1:0]     idx_raw;
   logic [IDX_W-1:0]     spawn_idx;

   btn_sync_edge #(
      .WIDTH (N_HOLES)
   ) u_btn_sync_edge (
      .clk  (clk),
      .rst  (rst),
      .d    (btn),
      .rise (btn_rise)
   );

   // Free-running; the all-zero lock-up state is unreachable from a nonzero seed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) lfsr_q <= SEED_EFF;
      else     lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
   end

   assign idx_raw   = IDX_W'(lfsr_q % LFSR_W'(N_HOLES));
   assign target_oh = N_HOLES'(1) << target_q;

   // Bump a repeated pick to the next hole so the same hole never lights twice.
   always_comb begin
      spawn_idx = idx_raw;
      if (N_HOLES > 1 && idx_raw == target_q)
         spawn_idx = (idx_raw == IDX_W'(N_HOLES - 1)) ? '0 : idx_raw + IDX_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         result_q <= RES_MISS;
         target_q <= '0;
         timer_q  <= '0;
         score_q  <= '0;
         misses_q <= '0;
         blink_q  <= 1'b0;
         hit_q    <= 1'b0;
         miss_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         target_q <= target_d;
         timer_q  <= timer_d;
         score_q  <= score_d;
         misses_q <= misses_d;
         blink_q  <= blink_d;
         hit_q    <= hit_d;
         miss_q   <= miss_d;
      end
   end

   // NOTE: every variable gets a default before the case so no path leaves it
   // unassigned, which is what would otherwise infer a latch.
   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      target_d = target_q;
      timer_d  = timer_q;
      score_d  = score_q;
      misses_d = misses_q;
      blink_d  = blink_q;
      hit_d    = 1'b0;
      miss_d   = 1'b0;

      case (state_q)
         IDLE: ;
         SPAWN: begin
            target_d = spawn_idx;
            timer_d  = T_WAIT;
            state_d  = WAIT;
         end
         WAIT: begin
            timer_d = timer_q - TIMER_W'(1);
            // A press in the timeout cycle still takes priority over the timeout.
            if (btn_rise != '0 || timer_q == '0) begin
               state_d = FLASH;
               timer_d = T_FLASH;
               if (btn_rise == target_oh) begin
                  hit_d    = 1'b1;
                  result_d = RES_HIT;
                  score_d  = (score_q == '1) ? score_q : score_q + SCORE_W'(1);
               end else begin
                  miss_d   = 1'b1;
                  result_d = RES_MISS;
                  misses_d = (misses_q == '1) ? misses_q : misses_q + SCORE_W'(1);
               end
            end
         end
         FLASH: begin
            if (timer_q == '0) begin
               if (misses_q == MISS_LIM) begin
                  state_d = OVER;
                  timer_d = T_FLASH;
                  blink_d = 1'b1;
               end else begin
                  state_d = SPAWN;
               end
            end else begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end
         OVER: begin
            if (timer_q == '0) begin
               timer_d = T_FLASH;
               blink_d = ~blink_q;
            end else begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // start overrides any decision made this cycle, including a pending hit/miss.
      if (start) begin
         state_d  = SPAWN;
         score_d  = '0;
         misses_d = '0;
         hit_d    = 1'b0;
         miss_d   = 1'b0;
      end
   end

   always_comb begin
      led = '0;
      case (state_q)
         WAIT:    led = target_oh;
         FLASH:   led = (result_q == RES_HIT) ? '1 : '0;
         OVER:    led = blink_q ? '1 : '0;
         default: led = '0;
      endcase
   end

   assign game_over = (state_q == OVER);
   assign hit       = hit_q;
   assign miss      = miss_q;
   assign score     = score_q;
   assign misses    = misses_q;

endmodule

// File: doc/zombie_target_gen.md
Name: zombie_target_gen

Overview:
Parametrised target generator and hit judge for the punch-zombie game. It selects a pseudo-random hole from N_HOLES using a free-running Galois LFSR and lights that hole's LED. It then judges synchronised button presses against the lit hole and keeps score and miss counts. It replaces the fixed 3-button, 2-bit-LFSR LED picker, adding per-round timeout, no-repeat target selection and a game-over state.

Parameters:
N_HOLES, 3, number of holes/buttons/LEDs (2..16)
LFSR_W, 16, LFSR width; must be 8, 16 or 32
SEED, 16'hACE1, LFSR reset value; 0 is replaced by 1
TIMEOUT_CYC, 31250000, clk cycles a target stays lit before it counts as a miss
FLASH_CYC, 6250000, clk cycles of result flash between rounds
SCORE_W, 8, width of score and miss counters
MAX_MISS, 5, miss count that ends the game (1..2^SCORE_W-1)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
start  in  1  synchronous pulse; starts or restarts a game
btn  in  N_HOLES  raw asynchronous buttons, active-high
led  out  N_HOLES  hole LEDs
hit  out  1  one-cycle pulse on a correct press
miss  out  1  one-cycle pulse on a wrong press or timeout
score  out  SCORE_W  hits this game, saturating
misses  out  SCORE_W  misses this game
game_over  out  1  high in OVER state

Behaviour:
- Reset values: state IDLE; led=0, hit=0, miss=0, score=0, misses=0, game_over=0; LFSR=SEED (1 if SEED==0); sync flops=0; target=0; timer=0.
- LFSR: Galois, advances every clk outside reset, never all-zero. Taps come from the package per LFSR_W: 8 uses x^8+x^6+x^5+x^4+1, 16 uses x^16+x^14+x^13+x^11+1, 32 uses x^32+x^22+x^2+x+1.
- Buttons: 2-flop synchroniser plus a delay flop per bit. The edge vector is sync & ~delayed. A raw rise appears in the edge vector on the 3rd clk edge.
- FSM states:
  - IDLE: led=0. start moves to SPAWN, clearing score and misses.
  - SPAWN (1 cycle): idx = lfsr[LFSR_W-1:0] mod N_HOLES. If idx==target and N_HOLES>1, idx = (idx+1) mod N_HOLES. Register idx into target, load timer=TIMEOUT_CYC-1, go to WAIT.
  - WAIT: led = one-hot(target); timer decrements.
    - Edge vector == one-hot(target): hit pulse, score+1 (saturates at all-ones), go to FLASH with result=hit.
    - Any other nonzero edge vector (wrong button, or several buttons including the correct one): miss pulse, misses+1, result=miss.
    - timer==0 with no edge: miss pulse, misses+1, result=miss.
    - An edge and timer==0 in the same cycle: the edge decides.
  - FLASH: timer loaded with FLASH_CYC-1 on entry. led is all-ones for a hit and 0 for a miss. Edges are ignored. At timer==0: go to OVER if misses==MAX_MISS, otherwise to SPAWN.
  - OVER: game_over=1; led alternates all-ones/0 every FLASH_CYC cycles. start goes to SPAWN and clears the counters.
- start in SPAWN, WAIT or FLASH restarts the game: clear counters, go to SPAWN. If start coincides with a WAIT edge, start wins and no hit/miss pulse is emitted.
- hit and miss are registered, appear the cycle after the decision, and are never high together.
- Asynchronous rst in any state returns everything to the reset values immediately.
- Edge latency: raw press to hit/miss pulse is 4 clk edges.

Decomposition:
- Package zombie_pkg holds: state enum (IDLE, SPAWN, WAIT, FLASH, OVER), LFSR tap-mask function lfsr_taps(width), result enum (RES_HIT, RES_MISS).
- Sub-module btn_sync_edge, parametrised by width, contains the synchroniser and rising-edge detect.
- LFSR, FSM, timer and counters stay in the top level.

Test Plan:
- Reset, then start=1 for one cycle with N_HOLES=3, TIMEOUT_CYC=20, FLASH_CYC=4, MAX_MISS=3 -> SPAWN on the next cycle, led one-hot with target = SEED-derived idx, score=0, misses=0.
- In WAIT, pulse the btn bit matching led -> hit high exactly 1 cycle, 4 clk edges after the raw rise; score=1; led=3'b111 for 4 cycles; new target differs from the previous one.
- In WAIT, press a non-target button, then press target and a non-target together in a later round -> miss each time, misses=2, led=0 during each flash.
- Hold buttons low for 20 WAIT cycles -> miss on the timeout; after the 3rd miss, game_over=1 and led toggles every 4 cycles; start -> counters 0, game_over=0.
- Raw press arriving so its edge lands in the same cycle as timer==0 -> judged as hit/miss from the edge, with exactly one pulse.
- Assert rst mid-WAIT and mid-FLASH -> all outputs 0 the same cycle; LFSR=SEED; with SEED=0, LFSR=1.
